// File: rtl/top_a1_q4_irq_ctrl_8.sv
// Eight-source edge-triggered interrupt controller: latches rising edges into pending,
// presents the highest-priority unmasked source and holds it until acknowledged.
module top_a1_q4_irq_ctrl_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       irq_ack,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending
);

  // state   | meaning
  // IDLE    | no grant presented; evaluates eligible sources every edge
  // PRESENT | irq_id frozen and valid until irq_ack

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state;
  logic [7:0] irq_in_d;
  logic [7:0] rise;
  logic [7:0] eligible;
  logic [7:0] clr;
  logic [2:0] top_idx;

  always_comb begin
    rise     = irq_in & ~irq_in_d;
    eligible = pending & ~mask;
    top_idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) top_idx = 3'(i);
    end
    clr = 8'h00;
    if (state == PRESENT && irq_ack) clr[irq_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // all-ones history keeps lines held high through reset from posting requests
      irq_in_d  <= 8'hFF;
      pending   <= 8'h00;
      irq_valid <= 1'b0;
      irq_id    <= 3'd0;
      state     <= IDLE;
    end else begin
      irq_in_d <= irq_in;
      // a fresh edge on the acknowledged source wins over its clear
      pending  <= (pending & ~clr) | rise;
      case (state)
        IDLE: begin
          if (|eligible) begin
            state     <= PRESENT;
            irq_valid <= 1'b1;
            irq_id    <= top_idx;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          irq_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_a1_q4_irq_ctrl_8.sv
// Self-checking bench for the 8-source interrupt controller; expected grant ids are
// queued when requests are driven and popped when the controller presents a grant.
module tb_top_a1_q4_irq_ctrl_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       irq_ack;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  top_a1_q4_irq_ctrl_8 dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .irq_ack(irq_ack),
    .irq_valid(irq_valid), .irq_id(irq_id), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // advances until irq_valid is seen, bounded; reports edges consumed
  task automatic wait_valid(output int n);
    n = 0;
    while (!irq_valid && n < 8) begin
      step();
      n++;
    end
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  // checks one grant: latency, valid, and id against the scoreboard head
  task automatic expect_grant(input string name);
    int n;
    int exp_id;
    wait_valid(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, expected 1", name, n);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got grant id %0d with no expected entry", name, irq_id);
    end else begin
      exp_id = exp_q.pop_front();
      if (irq_valid !== 1'b1 || irq_id !== 3'(exp_id)) begin
        errors++;
        $display("FAIL %s grant: got valid=%0b id=%0d, expected valid=1 id=%0d",
                 name, irq_valid, irq_id, exp_id);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_in = 8'h00; mask = 8'h00; irq_ack = 1'b0;
    step(2);
    rst = 1'b0;
    checks++;
    if (pending !== 8'h00 || irq_valid !== 1'b0 || irq_id !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got pending=%h valid=%0b id=%0d, expected 00 0 0",
               pending, irq_valid, irq_id);
    end
    step();
  endtask

  task automatic test_single();
    irq_in = 8'h08;
    exp_q.push_back(3);
    step();
    checks++;
    if (pending !== 8'h08 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_edge: got pending=%h valid=%0b, expected 08 0", pending, irq_valid);
    end
    expect_grant("single");
    ack_once();
    checks++;
    if (pending !== 8'h00 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: got pending=%h valid=%0b, expected 00 0", pending, irq_valid);
    end
    step(2);
    checks++;
    if (pending !== 8'h00 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_held: got pending=%h valid=%0b, expected 00 0", pending, irq_valid);
    end
    irq_in = 8'h00;
    step();
  endtask

  task automatic test_priority();
    logic [7:0] exp_pend[3] = '{8'h25, 8'h05, 8'h01};
    irq_in = 8'h25;
    exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(0);
    step();
    for (int k = 0; k < 3; k++) begin
      expect_grant("priority");
      checks++;
      if (pending !== exp_pend[k]) begin
        errors++;
        $display("FAIL priority_pending: got %h, expected %h", pending, exp_pend[k]);
      end
      ack_once();
      checks++;
      if (irq_valid !== 1'b0) begin
        errors++;
        $display("FAIL priority_idle_gap: got valid=%0b, expected 0", irq_valid);
      end
    end
    checks++;
    if (pending !== 8'h00) begin
      errors++;
      $display("FAIL priority_drain: got pending=%h, expected 00", pending);
    end
    irq_in = 8'h00;
    step();
  endtask

  task automatic test_mask();
    mask = 8'h80;
    irq_in = 8'h81;
    exp_q.push_back(0);
    step();
    expect_grant("mask_low");
    ack_once();
    checks++;
    if (pending !== 8'h80 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL mask_latched: got pending=%h valid=%0b, expected 80 0", pending, irq_valid);
    end
    step(2);
    checks++;
    if (irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL mask_blocks: got valid=%0b, expected 0", irq_valid);
    end
    mask = 8'h00;
    exp_q.push_back(7);
    expect_grant("mask_release");
    ack_once();
    checks++;
    if (pending !== 8'h00) begin
      errors++;
      $display("FAIL mask_drain: got pending=%h, expected 00", pending);
    end
    irq_in = 8'h00;
    step();
  endtask

  task automatic test_stability();
    irq_in = 8'h04;
    exp_q.push_back(2);
    step();
    expect_grant("stable_first");
    irq_in = 8'h44;
    mask = 8'h04;
    step(3);
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd2 || pending !== 8'h44) begin
      errors++;
      $display("FAIL stable_hold: got valid=%0b id=%0d pending=%h, expected 1 2 44",
               irq_valid, irq_id, pending);
    end
    ack_once();
    checks++;
    if (irq_valid !== 1'b0 || pending !== 8'h40) begin
      errors++;
      $display("FAIL stable_ack: got valid=%0b pending=%h, expected 0 40", irq_valid, pending);
    end
    exp_q.push_back(6);
    expect_grant("stable_next");
    ack_once();
    mask = 8'h00;
    irq_in = 8'h00;
    step();
  endtask

  task automatic test_set_ack();
    irq_in = 8'h10;
    exp_q.push_back(4);
    step();
    expect_grant("setack_first");
    irq_in = 8'h00;
    step();
    irq_in = 8'h10;
    ack_once();
    checks++;
    if (pending !== 8'h10 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL setack_set_wins: got pending=%h valid=%0b, expected 10 0", pending, irq_valid);
    end
    exp_q.push_back(4);
    expect_grant("setack_regrant");
    ack_once();
    checks++;
    if (pending !== 8'h00) begin
      errors++;
      $display("FAIL setack_drain: got pending=%h, expected 00", pending);
    end
    irq_in = 8'h00;
    step();
  endtask

  task automatic test_idle_ack();
    mask = 8'hFF;
    irq_in = 8'h08;
    step();
    ack_once();
    step();
    checks++;
    if (pending !== 8'h08 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack: got pending=%h valid=%0b, expected 08 0", pending, irq_valid);
    end
    mask = 8'h00;
    exp_q.push_back(3);
    expect_grant("idle_ack_release");
    ack_once();
    irq_in = 8'h00;
    step();
  endtask

  task automatic test_reset_hold();
    irq_in = 8'hFF;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pending !== 8'h00 || irq_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got pending=%h valid=%0b, expected 00 0", pending, irq_valid);
      end
      step();
    end
    irq_in = 8'h00;
    step();
  endtask

  task automatic test_reset_mid();
    irq_in = 8'h06;
    exp_q.push_back(2);
    step();
    expect_grant("reset_mid_grant");
    rst = 1'b1;
    irq_ack = 1'b1;
    irq_in = 8'h07;
    step();
    rst = 1'b0;
    irq_ack = 1'b0;
    checks++;
    if (pending !== 8'h00 || irq_valid !== 1'b0 || irq_id !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: got pending=%h valid=%0b id=%0d, expected 00 0 0",
               pending, irq_valid, irq_id);
    end
    step(2);
    checks++;
    if (pending !== 8'h00 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: got pending=%h valid=%0b, expected 00 0", pending, irq_valid);
    end
    irq_in = 8'h00;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_stability();
    test_set_ack();
    test_idle_ack();
    test_reset_hold();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/top_a1_q4_irq_ctrl_8.md
TOP_A1_Q4_IRQ_CTRL_8 -- requirements
Module: top_a1_q4_irq_ctrl_8

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 irq_in  input  8  raw interrupt request lines; bit i = source i; level, asynchronous to nothing (already clk-synchronous).
REQ-005 mask  input  8  per-source mask; 1 = source i not eligible for grant (still latched).
REQ-006 irq_ack  input  1  consumer acknowledge of the presented id.
REQ-007 irq_valid  output  1  registered; 1 = irq_id holds a granted source.
REQ-008 irq_id  output  3  registered; binary index of granted source (7 = highest priority).
REQ-009 pending  output  8  registered; latched, not-yet-serviced requests.

Function
REQ-010 The block SHALL keep an internal 8-bit register irq_in_d holding irq_in from the previous clock edge.
REQ-011 Rising edge on source i SHALL be detected at any clock edge where irq_in[i]=1 and irq_in_d[i]=0, setting pending[i] at that edge.
REQ-012 Held-high levels SHALL NOT re-set pending; a new 0->1 transition is required.
REQ-013 eligible SHALL be defined as pending AND NOT mask, evaluated on current register/input values.
REQ-014 FSM SHALL have two states: IDLE (irq_valid=0) and PRESENT (irq_valid=1).
REQ-015 IDLE -> PRESENT at a clock edge where eligible != 0; irq_id SHALL load the index of the most significant set bit of eligible at that edge.
REQ-016 PRESENT -> IDLE at a clock edge where irq_ack=1; pending[irq_id] SHALL clear at that edge.
REQ-017 If a new rising edge on source irq_id coincides with the ack edge, pending[irq_id] SHALL remain 1 (set wins).
REQ-018 In PRESENT, irq_id and irq_valid SHALL be stable until ack; mask changes or higher-priority arrivals SHALL NOT alter the grant.
REQ-019 irq_ack in IDLE SHALL be ignored (no pending change).
REQ-020 After an ack the FSM SHALL spend exactly one cycle in IDLE before the next grant (irq_valid low for one cycle between grants).
REQ-021 Latency: edge detected at clock edge N (pending set) -> irq_valid=1 after edge N+1, provided FSM was IDLE and source unmasked.
REQ-022 Masked pending bits SHALL become eligible the cycle mask clears, without a new edge.
REQ-023 No pending bit SHALL clear except by ack of its id or reset.

Reset
REQ-024 At a clock edge with rst=1: pending=8'h00, irq_valid=0, irq_id=3'b000, FSM=IDLE, irq_in_d=8'hFF.
REQ-025 irq_in_d reset to all ones SHALL ensure lines held high through reset produce no request after release.
REQ-026 rst asserted during PRESENT SHALL abort the grant and discard all pending requests at that edge.
REQ-027 rst SHALL take priority over edge detection and irq_ack in the same cycle.

Verification
REQ-028 Single source: mask=00, irq_in 00->08 at edge N -> pending=08 after N, irq_valid=1, irq_id=3 after N+1; ack one cycle -> pending=00, irq_valid=0.
REQ-029 Priority: irq_in 00->25 in one cycle -> grants in order id 5, 2, 0, each after ack, one idle cycle between, pending 25->05->01->00.
REQ-030 Mask: mask=80, irq_in 00->81 -> grant id 0 only, pending[7] stays set; clear mask -> id 7 granted next IDLE evaluation with no new edge.
REQ-031 Stability: in PRESENT with id 2, raise source 6 and set mask=04 -> irq_id stays 2 until ack, then id 6 granted.
REQ-032 Simultaneous set/ack: while id 4 presented, drop irq_in[4] then re-raise it so the edge coincides with ack -> pending[4] remains 1, id 4 re-granted after one idle cycle.
REQ-033 Reset: irq_in=FF held through rst and after release, no toggles -> pending stays 00, irq_valid stays 0; rst mid-PRESENT -> all outputs to reset values next edge.
